simd_vector_sequencer: RTL and testbench

- Parametrised next-generation SIMD processor core.
- Fetches instructions from the instruction memory and reads one PE_ELEMENTS-wide vector from RAM A and one from RAM B.
- Applies a lane-parallel operation to the two vectors and writes the vector result to the result RAM.
- Adds beyond the previous generation: an explicit multi-cycle sequencer, a wider opcode set, a selectable signed-saturating arithmetic mode, a per-lane write mask and a busy/stop status handshake.

---
 rtl/simd_vector_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_simd_vector_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_vector_sequencer.sv
// Multi-cycle SIMD sequencer: fetches instructions, reads an A/B vector pair,
// applies a lane-parallel op (optional signed saturation, per-lane mask) and writes the result.
module simd_vector_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 4,
  parameter int PE_ELEMENTS     = 4,
  parameter int DRAM_DEPTH      = 256,
  parameter int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH),
  parameter int INST_LEN        = OPCODE_WIDTH + DRAM_ADDR_WIDTH,
  parameter int PC_LEN          = 12
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                valid,
  input  logic                                sat_mode,
  input  logic [PE_ELEMENTS-1:0]              lane_mask,
  output logic                                busy,
  output logic                                stop,
  input  logic [INST_LEN-1:0]                 inst_read_data,
  output logic [PC_LEN-1:0]                   inst_read_addr,
  input  logic [DATA_WIDTH*PE_ELEMENTS-1:0]   ram_a_read_data,
  output logic [DRAM_ADDR_WIDTH-1:0]          ram_a_read_addr,
  output logic                                ram_a_rd_en,
  input  logic [DATA_WIDTH*PE_ELEMENTS-1:0]   ram_b_read_data,
  output logic [DRAM_ADDR_WIDTH-1:0]          ram_b_read_addr,
  output logic                                ram_b_rd_en,
  output logic [DRAM_ADDR_WIDTH-1:0]          ram_result_write_addr,
  output logic [DATA_WIDTH*PE_ELEMENTS-1:0]   ram_result_write_data,
  output logic                                ram_result_wr_en
);

  localparam int VW = DATA_WIDTH * PE_ELEMENTS;
  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_MAX  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_MIN  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_IWAIT, S_DECODE, S_READ, S_EXEC, S_WRITE, S_DONE
  } state_t;

  state_t                      state_q;
  logic [PC_LEN-1:0]           pc_q;
  logic                        sat_q;
  logic [PE_ELEMENTS-1:0]      mask_q;
  logic [OPCODE_WIDTH-1:0]     opcode_q;
  logic [DRAM_ADDR_WIDTH-1:0]  addr_q;
  logic                        busy_q, stop_q, rd_en_q, wr_en_q;
  logic [VW-1:0]               opa_q, opb_q, res_q, res_d;

  logic [OPCODE_WIDTH-1:0]     inst_op;
  logic [DRAM_ADDR_WIDTH-1:0]  inst_addr;
  logic                        pc_last;

  assign inst_op   = inst_read_data[INST_LEN-1 -: OPCODE_WIDTH];
  assign inst_addr = inst_read_data[DRAM_ADDR_WIDTH-1:0];
  assign pc_last   = (pc_q == '1);

  function automatic logic is_exec(input logic [OPCODE_WIDTH-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MIN);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] add_sat(
    input logic signed [DATA_WIDTH-1:0] a, input logic signed [DATA_WIDTH-1:0] b, input logic sat);
    logic signed [DATA_WIDTH-1:0] s;
    s = a + b;
    if (sat && (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]))
      s = a[DATA_WIDTH-1] ? SMIN : SMAX;
    return s;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sub_sat(
    input logic signed [DATA_WIDTH-1:0] a, input logic signed [DATA_WIDTH-1:0] b, input logic sat);
    logic signed [DATA_WIDTH-1:0] s;
    s = a - b;
    if (sat && (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]))
      s = a[DATA_WIDTH-1] ? SMIN : SMAX;
    return s;
  endfunction

  // Lane datapath; masked lanes pass A through so the write is a read-modify-write
  always_comb begin
    logic signed [DATA_WIDTH-1:0] a, b, r;
    res_d = '0;
    a = '0;
    b = '0;
    r = '0;
    for (int i = 0; i < PE_ELEMENTS; i++) begin
      a = opa_q[i*DATA_WIDTH +: DATA_WIDTH];
      b = opb_q[i*DATA_WIDTH +: DATA_WIDTH];
      case (opcode_q)
        OP_ADD:  r = add_sat(a, b, sat_q);
        OP_SUB:  r = sub_sat(a, b, sat_q);
        OP_MUL:  r = a * b;
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_MAX:  r = (a > b) ? a : b;
        OP_MIN:  r = (a < b) ? a : b;
        default: r = a;
      endcase
      if (!mask_q[i]) r = a;
      res_d[i*DATA_WIDTH +: DATA_WIDTH] = r;
    end
  end

  // Operand capture: data only, no reset needed
  always_ff @(posedge clk) begin
    if (state_q == S_READ) begin
      opa_q <= ram_a_read_data;
      opb_q <= ram_b_read_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      sat_q    <= 1'b0;
      mask_q   <= '0;
      opcode_q <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      stop_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      res_q    <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (valid) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            sat_q   <= sat_mode;
            mask_q  <= lane_mask;
            busy_q  <= 1'b1;
            stop_q  <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_IWAIT;
        S_IWAIT: begin
          opcode_q <= inst_op;
          addr_q   <= inst_addr;
          rd_en_q  <= is_exec(inst_op);
          state_q  <= S_DECODE;
        end
        S_DECODE, S_WRITE: begin
          if (state_q == S_DECODE && is_exec(opcode_q)) begin
            state_q <= S_READ;
          end else if ((state_q == S_DECODE && opcode_q == OP_HALT) || pc_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            stop_q  <= 1'b1;
          end else begin
            pc_q    <= pc_q + PC_LEN'(1);
            state_q <= S_FETCH;
          end
        end
        S_READ: state_q <= S_EXEC;
        S_EXEC: begin
          res_q   <= res_d;
          wr_en_q <= 1'b1;
          state_q <= S_WRITE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy                  = busy_q;
  assign stop                  = stop_q;
  assign inst_read_addr        = pc_q;
  assign ram_a_read_addr       = addr_q;
  assign ram_b_read_addr       = addr_q;
  assign ram_result_write_addr = addr_q;
  assign ram_a_rd_en           = rd_en_q;
  assign ram_b_rd_en           = rd_en_q;
  assign ram_result_wr_en      = wr_en_q;
  assign ram_result_write_data = res_q;

endmodule

// File: tb/tb_simd_vector_sequencer.sv
// Directed bench for simd_vector_sequencer: default build plus a PC_LEN=2 build for PC-end behaviour.
module tb_simd_vector_sequencer;
  localparam int DW = 32, PE = 4, AW = 8, IL = 12, VW = DW * PE;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic valid = 1'b0, valid2 = 1'b0, sat_mode = 1'b0;
  logic [PE-1:0] lane_mask = '1;

  logic busy, stop, ra_en, rb_en, wen;
  logic [IL-1:0] inst_rd;
  logic [11:0] ia;
  logic [VW-1:0] ra_d, rb_d, wdata;
  logic [AW-1:0] ra_a, rb_a, waddr;

  logic busy2, stop2, ra_en2, rb_en2, wen2;
  logic [IL-1:0] inst_rd2;
  logic [1:0] ia2;
  logic [VW-1:0] ra_d2, rb_d2, wdata2;
  logic [AW-1:0] ra_a2, rb_a2, waddr2;

  simd_vector_sequencer dut (
    .clk(clk), .rstn(rstn), .valid(valid), .sat_mode(sat_mode), .lane_mask(lane_mask),
    .busy(busy), .stop(stop), .inst_read_data(inst_rd), .inst_read_addr(ia),
    .ram_a_read_data(ra_d), .ram_a_read_addr(ra_a), .ram_a_rd_en(ra_en),
    .ram_b_read_data(rb_d), .ram_b_read_addr(rb_a), .ram_b_rd_en(rb_en),
    .ram_result_write_addr(waddr), .ram_result_write_data(wdata), .ram_result_wr_en(wen));

  simd_vector_sequencer #(.PC_LEN(2)) dut2 (
    .clk(clk), .rstn(rstn), .valid(valid2), .sat_mode(sat_mode), .lane_mask(lane_mask),
    .busy(busy2), .stop(stop2), .inst_read_data(inst_rd2), .inst_read_addr(ia2),
    .ram_a_read_data(ra_d2), .ram_a_read_addr(ra_a2), .ram_a_rd_en(ra_en2),
    .ram_b_read_data(rb_d2), .ram_b_read_addr(rb_a2), .ram_b_rd_en(rb_en2),
    .ram_result_write_addr(waddr2), .ram_result_write_data(wdata2), .ram_result_wr_en(wen2));

  logic [IL-1:0] imem [0:15];
  logic [IL-1:0] imem2 [0:3];
  logic [VW-1:0] amem [0:255];
  logic [VW-1:0] bmem [0:255];
  logic [VW-1:0] rmem [0:255];
  logic [VW-1:0] rmem2 [0:255];

  always @(posedge clk) begin
    inst_rd  <= imem[ia[3:0]];
    inst_rd2 <= imem2[ia2];
    if (ra_en)  ra_d  <= amem[ra_a];
    if (rb_en)  rb_d  <= bmem[rb_a];
    if (ra_en2) ra_d2 <= amem[ra_a2];
    if (rb_en2) rb_d2 <= bmem[rb_a2];
    if (wen)  rmem[waddr]   <= wdata;
    if (wen2) rmem2[waddr2] <= wdata2;
  end

  int cyc = 0, wr_hi = 0, wr_cyc = 0, fetch_cyc = 0, both_hi = 0, wr2_hi = 0;
  logic busy_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wen) begin
      wr_hi  <= wr_hi + 1;
      wr_cyc <= cyc;
    end
    if (wen && (ra_en || rb_en)) both_hi <= both_hi + 1;
    if (busy === 1'b1 && busy_prev !== 1'b1) fetch_cyc <= cyc;
    busy_prev <= busy;
    if (wen2) wr2_hi <= wr2_hi + 1;
  end

  int n_cmp = 0, n_err = 0;

  function automatic logic [VW-1:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [IL-1:0] ins(input logic [3:0] op, input logic [7:0] a);
    return {op, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic sat, input logic [PE-1:0] mask);
    sat_mode  = sat;
    lane_mask = mask;
    valid     = 1'b1;
    step();
    valid     = 1'b0;
  endtask

  task automatic wait_stop(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (stop === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (stop !== 1'b0) begin n_err++; $display("FAIL reset_stop got=%b exp=0", stop); end
    n_cmp++; if ({wen, ra_en, rb_en} !== 3'b000) begin n_err++; $display("FAIL reset_strobes got=%b exp=000", {wen, ra_en, rb_en}); end
    n_cmp++; if ({ia, ra_a, rb_a, waddr} !== '0) begin n_err++; $display("FAIL reset_addrs got=%h exp=0", {ia, ra_a, rb_a, waddr}); end
    n_cmp++; if (wdata !== '0) begin n_err++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_add();
    bit to;
    int w0;
    imem[0] = ins(4'h1, 8'd3);
    imem[1] = ins(4'hF, 8'd0);
    amem[3] = vec(1, 2, 3, 4);
    bmem[3] = vec(10, 20, 30, 40);
    rmem[3] = '0;
    w0 = wr_hi;
    start(1'b0, 4'hF);
    wait_stop(40, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL add_timeout got=%b exp=0", to); end
    n_cmp++; if (rmem[3] !== vec(11, 22, 33, 44)) begin n_err++; $display("FAIL add_result got=%h exp=%h", rmem[3], vec(11, 22, 33, 44)); end
    n_cmp++; if (wr_hi - w0 !== 1) begin n_err++; $display("FAIL add_wr_count got=%0d exp=1", wr_hi - w0); end
    n_cmp++; if (wr_cyc - fetch_cyc !== 5) begin n_err++; $display("FAIL add_wr_latency got=%0d exp=5", wr_cyc - fetch_cyc); end
    step(); step();
    n_cmp++; if ({stop, busy} !== 2'b10) begin n_err++; $display("FAIL add_done_status got=%b exp=10", {stop, busy}); end
  endtask

  task automatic test_saturation();
    bit to;
    imem[0] = ins(4'h1, 8'd4);
    imem[1] = ins(4'h2, 8'd5);
    imem[2] = ins(4'hF, 8'd0);
    amem[4] = vec(32'h7FFFFFFF, 32'h80000000, 5, 32'h7FFFFFFF);
    bmem[4] = vec(1, 32'hFFFFFFFF, -3, 32'h7FFFFFFF);
    amem[5] = vec(32'h80000000, 32'h7FFFFFFF, 10, 0);
    bmem[5] = vec(1, 32'hFFFFFFFF, 3, 32'h80000000);
    start(1'b1, 4'hF);
    wait_stop(60, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL sat_timeout got=%b exp=0", to); end
    n_cmp++; if (rmem[4] !== vec(32'h7FFFFFFF, 32'h80000000, 2, 32'h7FFFFFFF)) begin n_err++; $display("FAIL sat_add got=%h", rmem[4]); end
    n_cmp++; if (rmem[5] !== vec(32'h80000000, 32'h7FFFFFFF, 7, 32'h7FFFFFFF)) begin n_err++; $display("FAIL sat_sub got=%h", rmem[5]); end
    // restart straight from DONE with wrapping arithmetic
    sat_mode = 1'b0;
    valid = 1'b1;
    n_cmp++; if (stop !== 1'b1) begin n_err++; $display("FAIL restart_stop_before got=%b exp=1", stop); end
    step();
    valid = 1'b0;
    n_cmp++; if (stop !== 1'b0) begin n_err++; $display("FAIL restart_stop_after got=%b exp=0", stop); end
    n_cmp++; if (ia !== 12'd0) begin n_err++; $display("FAIL restart_pc got=%0d exp=0", ia); end
    wait_stop(60, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL wrap_timeout got=%b exp=0", to); end
    n_cmp++; if (rmem[4] !== vec(32'h80000000, 32'h7FFFFFFF, 2, 32'hFFFFFFFE)) begin n_err++; $display("FAIL wrap_add got=%h", rmem[4]); end
    n_cmp++; if (rmem[5] !== vec(32'h7FFFFFFF, 32'h80000000, 7, 32'h80000000)) begin n_err++; $display("FAIL wrap_sub got=%h", rmem[5]); end
  endtask

  task automatic test_ops();
    bit to;
    imem[0] = ins(4'h3, 8'd7);
    imem[1] = ins(4'h4, 8'd8);
    imem[2] = ins(4'h5, 8'd9);
    imem[3] = ins(4'h7, 8'd10);
    imem[4] = ins(4'hF, 8'd0);
    amem[7]  = vec(3, -2, 32'h10000, 7);
    bmem[7]  = vec(5, 6, 32'h10000, -1);
    amem[8]  = vec(32'hF0, 32'hFF, 0, 32'hFFFFFFFF);
    bmem[8]  = vec(32'h3C, 32'h0F, 32'hFF, 32'h12345678);
    amem[9]  = amem[8];
    bmem[9]  = bmem[8];
    amem[10] = vec(-5, 7, 0, 3);
    bmem[10] = vec(2, -9, 0, 3);
    start(1'b1, 4'hF);
    wait_stop(80, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL ops_timeout got=%b exp=0", to); end
    n_cmp++; if (rmem[7] !== vec(15, 32'hFFFFFFF4, 0, 32'hFFFFFFF9)) begin n_err++; $display("FAIL ops_mul got=%h", rmem[7]); end
    n_cmp++; if (rmem[8] !== vec(32'h30, 32'h0F, 0, 32'h12345678)) begin n_err++; $display("FAIL ops_and got=%h", rmem[8]); end
    n_cmp++; if (rmem[9] !== vec(32'hFC, 32'hFF, 32'hFF, 32'hFFFFFFFF)) begin n_err++; $display("FAIL ops_or got=%h", rmem[9]); end
    n_cmp++; if (rmem[10] !== vec(2, 7, 0, 3)) begin n_err++; $display("FAIL ops_max got=%h", rmem[10]); end
  endtask

  task automatic test_mask_xor();
    bit to;
    imem[0] = ins(4'h6, 8'd6);
    imem[1] = ins(4'hF, 8'd0);
    amem[6] = vec(32'hF, 32'hF, 32'hF, 32'hF);
    bmem[6] = vec(1, 1, 1, 1);
    rmem[6] = '0;
    start(1'b0, 4'b0101);
    wait_stop(40, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL mask_timeout got=%b exp=0", to); end
    n_cmp++; if (rmem[6] !== vec(32'hE, 32'hF, 32'hE, 32'hF)) begin n_err++; $display("FAIL mask_xor got=%h exp=%h", rmem[6], vec(32'hE, 32'hF, 32'hE, 32'hF)); end
  endtask

  task automatic test_nop_min();
    bit to;
    int w0;
    imem[0] = ins(4'h0, 8'd0);
    imem[1] = ins(4'hB, 8'd0);
    imem[2] = ins(4'h8, 8'd0);
    imem[3] = ins(4'hF, 8'd0);
    amem[0] = vec(-5, 7, 0, 3);
    bmem[0] = vec(2, -9, 0, 3);
    rmem[0] = '0;
    w0 = wr_hi;
    start(1'b0, 4'hF);
    step(); step(); step();
    valid = 1'b1;
    step();
    valid = 1'b0;
    wait_stop(40, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL nop_timeout got=%b exp=0", to); end
    n_cmp++; if (rmem[0] !== vec(-5, -9, 0, 3)) begin n_err++; $display("FAIL nop_min_result got=%h", rmem[0]); end
    n_cmp++; if (wr_hi - w0 !== 1) begin n_err++; $display("FAIL nop_wr_count got=%0d exp=1", wr_hi - w0); end
    n_cmp++; if (wr_cyc - fetch_cyc !== 11) begin n_err++; $display("FAIL nop_latency got=%0d exp=11", wr_cyc - fetch_cyc); end
  endtask

  task automatic test_reset_write();
    bit seen;
    int w0;
    imem[0] = ins(4'h1, 8'd3);
    imem[1] = ins(4'hF, 8'd0);
    rmem[3] = '0;
    w0 = wr_hi;
    seen = 1'b0;
    start(1'b0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      if (wen === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rstw_reach_write got=%b exp=1", seen); end
    rstn = 1'b0;
    #1;
    n_cmp++; if ({wen, busy, stop} !== 3'b000) begin n_err++; $display("FAIL rstw_outputs got=%b exp=000", {wen, busy, stop}); end
    n_cmp++; if (wdata !== '0 || waddr !== '0) begin n_err++; $display("FAIL rstw_data got=%h/%h exp=0", wdata, waddr); end
    step();
    rstn = 1'b1;
    step(); step();
    n_cmp++; if ({busy, stop} !== 2'b00) begin n_err++; $display("FAIL rstw_idle got=%b exp=00", {busy, stop}); end
    n_cmp++; if (rmem[3] !== '0 || wr_hi !== w0) begin n_err++; $display("FAIL rstw_dropped got=%h cnt=%0d exp=0 cnt=%0d", rmem[3], wr_hi, w0); end
  endtask

  task automatic test_pc_end();
    bit to;
    imem2[0] = ins(4'h1, 8'd1);
    imem2[1] = ins(4'h0, 8'd0);
    imem2[2] = ins(4'h0, 8'd0);
    imem2[3] = ins(4'h1, 8'd2);
    amem[1] = vec(1, 2, 3, 4);
    bmem[1] = vec(1, 1, 1, 1);
    amem[2] = vec(5, 5, 5, 5);
    bmem[2] = vec(6, 6, 6, 6);
    sat_mode = 1'b0;
    lane_mask = 4'hF;
    valid2 = 1'b1;
    step();
    valid2 = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (stop2 === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL pcend_timeout got=%b exp=0", to); end
    n_cmp++; if (wr2_hi !== 2) begin n_err++; $display("FAIL pcend_writes got=%0d exp=2", wr2_hi); end
    n_cmp++; if (ia2 !== 2'd3) begin n_err++; $display("FAIL pcend_pc got=%0d exp=3", ia2); end
    n_cmp++; if (rmem2[1] !== vec(2, 3, 4, 5) || rmem2[2] !== vec(11, 11, 11, 11)) begin n_err++; $display("FAIL pcend_results got=%h/%h", rmem2[1], rmem2[2]); end
    step(); step();
    n_cmp++; if ({stop2, busy2, wen2} !== 3'b100) begin n_err++; $display("FAIL pcend_hold got=%b exp=100", {stop2, busy2, wen2}); end
  endtask

  task automatic test_strobe_exclusive();
    n_cmp++; if (both_hi !== 0) begin n_err++; $display("FAIL strobe_overlap got=%0d exp=0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_saturation();
    test_ops();
    test_mask_xor();
    test_nop_min();
    test_reset_write();
    test_pc_end();
    test_strobe_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
